axis_vec_fork2: RTL
===================

Name: axis_vec_fork2

Overview:
- Splits one joined vector-pair stream (lambda tile + x_t tile) into two independent valid/ready streams, A (lambda) and B (x_t).
- It is the inverse of the two-way stream join. It lets two consumers run with skew of up to DEPTH tiles while the producer issues each pair once.
- Each branch has its own circular FIFO.
- Every accepted pair is tagged with a wrapping sequence number so downstream logic can check that the branches stay aligned.

Parameters:
- TILE_SIZE, 4, elements per vector tile.
- DATA_WIDTH, 16, bits per element.
- DEPTH, 4, per-branch FIFO depth in tiles; must be a power of 2 and at least 2.
- SEQ_W, 8, width of the sequence tag.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  joined input is valid.
- in_ready  out  1  joined input can be accepted.
- lam_vec  in  DATA_WIDTH x TILE_SIZE  lambda tile.
- xt_vec  in  DATA_WIDTH x TILE_SIZE  x_t tile.
- a_valid  out  1  branch A has data.
- a_ready  in  1  branch A consumer is ready.
- a_vec  out  DATA_WIDTH x TILE_SIZE  lambda tile at the head of FIFO A.
- a_seq  out  SEQ_W  tag of the head of FIFO A.
- b_valid  out  1  branch B has data.
- b_ready  in  1  branch B consumer is ready.
- b_vec  out  DATA_WIDTH x TILE_SIZE  x_t tile at the head of FIFO B.
- b_seq  out  SEQ_W  tag of the head of FIFO B.
- a_level  out  clog2(DEPTH)+1  FIFO A occupancy.
- b_level  out  clog2(DEPTH)+1  FIFO B occupancy.

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - Clears all pointers, counts, sequence counter and FIFO memories.
  - After reset: a_valid=b_valid=0, a_vec=b_vec=0, a_seq=b_seq=0, a_level=b_level=0, in_ready=1.
  - Asserting rst mid-transfer discards all buffered tiles. No partial state survives.
- Ready rule:
  - in_ready = (a_count<DEPTH) && (b_count<DEPTH), computed from registered counts only.
  - A pop in the same cycle does not raise in_ready. This is deliberate, to avoid a ready-to-ready combinational path.
- Accept (in_valid && in_ready):
  - Writes lam_vec into A[a_wr] and xt_vec into B[b_wr].
  - Both entries get tag seq_cnt.
  - a_wr, b_wr and seq_cnt each increment by 1.
  - The pair goes into both FIFOs or neither; a one-sided push never occurs.
- Outputs:
  - a_valid = (a_count != 0); a_vec and a_seq are read combinationally from A[a_rd].
  - Branch B mirrors branch A.
- Pop:
  - a_valid && a_ready increments a_rd.
  - Branches pop independently; simultaneous pops on A and B are allowed.
- Counts:
  - a_count_next = a_count + push - popA; b_count follows the same rule with popB.
  - Same-cycle push and pop leaves the count unchanged and must be supported at every occupancy, including 0 with in_ready=1 and DEPTH-1.
- Wrap-around: pointers are clog2(DEPTH) bits and wrap naturally; seq_cnt wraps modulo 2^SEQ_W.
- Latency: an accepted tile appears on a_vec/b_vec on the next cycle (1-cycle fall-through from the registered memory). There is no bypass.
- Skew:
  - If branch A stalls while B drains, A fills.
  - in_ready drops once a_count=DEPTH, regardless of B.
- Stability: while a_valid && !a_ready, a_vec and a_seq hold steady. Branch B follows the same rule.
- Invariant: tags leave each branch in strict increasing order (mod 2^SEQ_W), with no gaps or duplicates.
- Output ports are never X after reset.

Decomposition:
- Shared package axis_vec_pkg holds:
  - the vec_t typedef (DATA_WIDTH x TILE_SIZE array);
  - the default TILE_SIZE and DATA_WIDTH;
  - a helper function for level width.
- One sub-module is natural: vec_tag_fifo (parameterised circular FIFO holding a vec_t plus an SEQ_W tag, with count output and same-cycle push/pop).
  - It is instantiated twice.
  - The top level holds in_ready, the joint push and seq_cnt.

Test Plan:
- Reset then idle:
  - With rst=1 for 3 cycles: all outputs 0 and in_ready=1.
  - After release with in_valid=0 for 10 cycles: a_valid=b_valid=0.
- Lockstep streaming:
  - Stimulus: a_ready=b_ready=1; 8 pairs pushed back-to-back with lam element0=k, xt element0=100+k.
  - Response: each branch emits seq 0..7 one cycle after accept, at 1 tile/cycle; in_ready stays 1; levels never exceed 1.
- Skew/full:
  - Stimulus: a_ready=0, b_ready=1; push 6 pairs.
  - Response: after 4 accepts a_level=4 and in_ready=0; B has emitted seq 0..3; pairs 4 and 5 stall.
  - Then a_ready=1: A emits seq 0..5 in order and the stalled pairs are accepted.
- Same-cycle push/pop at full-1:
  - Stimulus: fill to a_level=3, then hold a_ready=1 with in_valid=1.
  - Response: a_level stays 3 each cycle and the data order is preserved.
- Wrap:
  - Stimulus: SEQ_W=8; stream 300 pairs with random a_ready/b_ready at 50%.
  - Response: a_seq and b_seq sequences are both 0..255,0..43 with no gaps, and the data matches the scoreboard.
- Reset mid-operation:
  - Stimulus: with a_level=3 and b_level=1, pulse rst for 1 cycle asynchronously (off-edge).
  - Response: valids drop immediately, levels=0, and the next accepted pair carries seq 0.

Source files
------------

// File: rtl/axis_vec_pkg.sv
// Shared types and helpers for the vector-pair fork and its tagged FIFOs.
package axis_vec_pkg;

  localparam int DEF_TILE_SIZE  = 4;
  localparam int DEF_DATA_WIDTH = 16;

  // One vector tile at the default geometry.
  typedef logic [DEF_TILE_SIZE-1:0][DEF_DATA_WIDTH-1:0] vec_t;

  // Occupancy counters need one extra bit so that "full" (== depth) is representable.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vec_tag_fifo.sv
// Circular FIFO holding a vector tile plus a sequence tag per entry.
// Head entry is read combinationally from the registered memory, and
// push and pop may happen in the same cycle at any occupancy.
// The caller must never push while the FIFO is full.
module vec_tag_fifo
  import axis_vec_pkg::*;
#(
  parameter int TILE_SIZE  = DEF_TILE_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int SEQ_W      = 8,
  localparam int AW        = $clog2(DEPTH),
  localparam int LW        = level_w(DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 push,
  input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] wr_vec,
  input  logic [SEQ_W-1:0]                     wr_seq,
  input  logic                                 pop_ready,
  output logic                                 valid,
  output logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] rd_vec,
  output logic [SEQ_W-1:0]                     rd_seq,
  output logic [LW-1:0]                        count
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);

  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [SEQ_W-1:0]                     tag_r [DEPTH];
  logic [AW-1:0]                        wr_ptr_r;
  logic [AW-1:0]                        rd_ptr_r;
  logic [LW-1:0]                        count_r;
  logic [LW-1:0]                        count_next_s;
  logic                                 pop_s;

  // A pop only happens when the head is actually valid.
  always_comb begin
    pop_s = pop_ready && (count_r != {LW{1'b0}});
  end

  // Occupancy update: simultaneous push and pop cancel out.
  always_comb begin
    count_next_s = count_r;
    case ({push, pop_s})
      2'b10:   count_next_s = count_r + LVL_ONE;
      2'b01:   count_next_s = count_r - LVL_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {LW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
    end
  end

  // Storage; cleared on reset so the head outputs are never X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
        tag_r[i] <= {SEQ_W{1'b0}};
      end
    end else if (push) begin
      mem_r[wr_ptr_r] <= wr_vec;
      tag_r[wr_ptr_r] <= wr_seq;
    end
  end

  // Head of queue and status, straight from registered state.
  always_comb begin
    valid  = (count_r != {LW{1'b0}});
    rd_vec = mem_r[rd_ptr_r];
    rd_seq = tag_r[rd_ptr_r];
    count  = count_r;
  end

endmodule

// File: rtl/axis_vec_fork2.sv
// Splits a joined (lambda, x_t) tile stream into two independently
// draining branches, each buffered up to DEPTH tiles and tagged with a
// shared wrapping sequence number so consumers can check alignment.
module axis_vec_fork2
  import axis_vec_pkg::*;
#(
  parameter int TILE_SIZE  = DEF_TILE_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int SEQ_W      = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] lam_vec,
  input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] xt_vec,
  output logic                                 a_valid,
  input  logic                                 a_ready,
  output logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] a_vec,
  output logic [SEQ_W-1:0]                     a_seq,
  output logic                                 b_valid,
  input  logic                                 b_ready,
  output logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] b_vec,
  output logic [SEQ_W-1:0]                     b_seq,
  output logic [$clog2(DEPTH):0]               a_level,
  output logic [$clog2(DEPTH):0]               b_level
);

  localparam int            LW       = level_w(DEPTH);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [SEQ_W-1:0] SEQ_ONE = SEQ_W'(1);

  logic [SEQ_W-1:0] seq_cnt_r;
  logic             push_s;

  // Ready depends on registered occupancy only, so a same-cycle pop
  // never feeds back into in_ready combinationally.
  always_comb begin
    in_ready = (a_level < LVL_FULL) && (b_level < LVL_FULL);
    push_s   = in_valid && in_ready;
  end

  // Sequence tag of the next accepted pair; wraps modulo 2^SEQ_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_cnt_r <= {SEQ_W{1'b0}};
    end else if (push_s) begin
      seq_cnt_r <= seq_cnt_r + SEQ_ONE;
    end
  end

  vec_tag_fifo #(
    .TILE_SIZE  (TILE_SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .SEQ_W      (SEQ_W)
  ) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .wr_vec    (lam_vec),
    .wr_seq    (seq_cnt_r),
    .pop_ready (a_ready),
    .valid     (a_valid),
    .rd_vec    (a_vec),
    .rd_seq    (a_seq),
    .count     (a_level)
  );

  vec_tag_fifo #(
    .TILE_SIZE  (TILE_SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .SEQ_W      (SEQ_W)
  ) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .wr_vec    (xt_vec),
    .wr_seq    (seq_cnt_r),
    .pop_ready (b_ready),
    .valid     (b_valid),
    .rd_vec    (b_vec),
    .rd_seq    (b_seq),
    .count     (b_level)
  );

endmodule
